// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect, and decode handoff.
// The master modport is the fetch unit; the slave modport is the memory/decode side.
interface fetch_prefetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;

    // valid/ready: a transfer happens on a posedge where both are high; imem_req/imem_addr
    // and inst_valid/inst/inst_pc hold steady while waiting for imem_gnt / inst_ready.
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_pc4,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: owns the PC, issues pipelined reads, buffers in-order returns.
// Optional FETCH_PERF_EN adds saturating stall-cycle and flush counters.
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic clk,
    input  logic rst,
`ifdef FETCH_PERF_EN
    output logic [15:0] perf_stall_cycles,
    output logic [15:0] perf_flush_count,
`endif
    fetch_prefetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t PTR_ONE   = ptr_t'(1);
    localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);

    logic [31:0] slot_pc   [DEPTH];
    logic [31:0] slot_data [DEPTH];

    // Slots between fill_ptr and alloc_ptr are in flight; between head_ptr and fill_ptr are filled.
    ptr_t        alloc_ptr, fill_ptr, head_ptr;
    ptr_t        alloc_count, unfilled_count;
    ptr_t        drop_cnt;
    logic [31:0] fetch_pc;
    logic [AW-1:0] alloc_idx, fill_idx, head_idx;
    logic        issue, fill, deq, head_filled, q_empty;
    logic        unused_pc_bits;

    assign alloc_idx      = alloc_ptr[AW-1:0];
    assign fill_idx       = fill_ptr[AW-1:0];
    assign head_idx       = head_ptr[AW-1:0];
    assign alloc_count    = alloc_ptr - head_ptr;
    assign unfilled_count = alloc_ptr - fill_ptr;
    assign q_empty        = (alloc_ptr == head_ptr);
    assign head_filled    = (fill_ptr != head_ptr);
    assign unused_pc_bits = &{1'b0, bus.redirect_pc[1:0]};

    assign bus.imem_req  = !rst && !bus.redirect && (alloc_count < PTR_DEPTH) && (drop_cnt == '0);
    assign bus.imem_addr = fetch_pc;
    assign issue         = bus.imem_req && bus.imem_gnt;
    assign fill          = bus.imem_rvalid && (drop_cnt == '0) && (unfilled_count != '0);

    assign bus.inst_valid = head_filled && !bus.redirect;
    assign bus.inst       = head_filled ? slot_data[head_idx] : 32'h0;
    assign bus.inst_pc    = q_empty ? RESET_PC : slot_pc[head_idx];
    assign bus.inst_pc4   = bus.inst_pc + PC_STEP;
    assign deq            = bus.inst_valid && bus.inst_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= '0;
            fetch_pc  <= RESET_PC;
        end else if (bus.redirect) begin
            // Everything still in flight becomes wrong-path; a return this cycle is already gone.
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= drop_cnt + unfilled_count
                         - ptr_t'(bus.imem_rvalid && ((drop_cnt != '0) || (unfilled_count != '0)));
            fetch_pc  <= {bus.redirect_pc[31:2], 2'b00};
        end else begin
            if (issue) begin
                alloc_ptr <= alloc_ptr + PTR_ONE;
                fetch_pc  <= fetch_pc + PC_STEP;
            end
            if (fill) begin
                fill_ptr <= fill_ptr + PTR_ONE;
            end
            if (deq) begin
                head_ptr <= head_ptr + PTR_ONE;
            end
            if (bus.imem_rvalid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            slot_pc[alloc_idx] <= fetch_pc;
        end
        if (fill) begin
            slot_data[fill_idx] <= bus.imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= 16'h0;
            perf_flush_count  <= 16'h0;
        end else begin
            if (!bus.inst_valid && (perf_stall_cycles != 16'hFFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 16'd1;
            end
            if (bus.redirect && (perf_flush_count != 16'hFFFF)) begin
                perf_flush_count <= perf_flush_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: in-order memory model plus expected-instruction queue.
// Build with FETCH_PERF_EN defined to also exercise the performance counters.
module tb_fetch_prefetch_unit;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
        bit          stale;
    } mem_ent_t;

    logic clk;
    logic rst;
    fetch_prefetch_unit_if bus();
`ifdef FETCH_PERF_EN
    logic [15:0] perf_stall_cycles;
    logic [15:0] perf_flush_count;
`endif

    fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clk (clk),
        .rst (rst),
`ifdef FETCH_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count),
`endif
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_ent_t    mem_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] got_addr_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_pc = 32'h0;
    int          mem_lat = 1;
    bit          rand_lat = 0, rand_gnt = 0, gnt_off = 0, mem_hold = 0;
    int          ready_mode = 1;
    bit          redir_req = 0;
    logic [31:0] redir_pc = 32'h0;
    int          dut_grants = 0, deliveries = 0;
    int          first_grant_cyc = -1, first_valid_cyc = -1;
    bit          capture_after_redir = 0, got_after_redir = 1;
    logic [31:0] first_pc_after_redir = 32'h0;
    int          redir_cyc = 0, first_grant_after_redir_cyc = -1;
    int          stall_cnt = 0, flush_cnt = 0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive at the negedge, sample 1 time unit later, advance model, return at next negedge.
    task automatic step();
        bit          ret_now, ret_stale, exp_req, exp_valid;
        int          stale_n, live_n, filled_n;
        logic [63:0] e;
        ret_now = 0;
        ret_stale = 0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        if (!mem_hold && mem_q.size() > 0 && cyc >= mem_q[0].cyc + mem_lat &&
            (!rand_lat || $urandom_range(0, 2) != 0)) begin
            ret_now = 1;
            ret_stale = mem_q[0].stale;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'h2000_0000 + mem_q[0].addr;
            mem_q.delete(0);
        end
        bus.imem_gnt = gnt_off ? 1'b0 : (rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1);
        case (ready_mode)
            0:       bus.inst_ready = 1'b0;
            1:       bus.inst_ready = 1'b1;
            default: bus.inst_ready = 1'($urandom_range(0, 1));
        endcase
        bus.redirect    = redir_req;
        bus.redirect_pc = redir_pc;
        #1;
        stale_n = (ret_now && ret_stale) ? 1 : 0;
        live_n  = (ret_now && !ret_stale) ? 1 : 0;
        foreach (mem_q[i]) begin
            if (mem_q[i].stale) stale_n++;
            else live_n++;
        end
        filled_n  = exp_q.size() - live_n;
        exp_req   = !redir_req && (exp_q.size() < DEPTH) && (stale_n == 0);
        exp_valid = !redir_req && (filled_n > 0);

        checks++;
        if (bus.imem_req !== exp_req) begin
            errors++;
            $display("FAIL imem_req cyc %0d: got %b expected %b", cyc, bus.imem_req, exp_req);
        end
        checks++;
        if (bus.inst_valid !== exp_valid) begin
            errors++;
            $display("FAIL inst_valid cyc %0d: got %b expected %b", cyc, bus.inst_valid, exp_valid);
        end
        if (exp_req) begin
            checks++;
            if (bus.imem_addr !== exp_pc) begin
                errors++;
                $display("FAIL imem_addr cyc %0d: got %h expected %h", cyc, bus.imem_addr, exp_pc);
            end
        end
        if (bus.imem_req && bus.imem_gnt) begin
            dut_grants++;
            if (capture_after_redir) begin
                if (got_addr_q.size() == 0) first_grant_after_redir_cyc = cyc;
                got_addr_q.push_back(bus.imem_addr);
            end
        end
        if (exp_valid && bus.inst_ready) begin
            e = exp_q.pop_front();
            deliveries++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (capture_after_redir && !got_after_redir) begin
                first_pc_after_redir = bus.inst_pc;
                got_after_redir = 1;
            end
            checks++;
            if (bus.inst_pc !== e[63:32] || bus.inst !== e[31:0] || bus.inst_pc4 !== e[63:32] + 32'd4) begin
                errors++;
                $display("FAIL deliver cyc %0d: got pc %h inst %h pc4 %h expected pc %h inst %h pc4 %h",
                         cyc, bus.inst_pc, bus.inst, bus.inst_pc4, e[63:32], e[31:0], e[63:32] + 32'd4);
            end
        end
        if (exp_req && bus.imem_gnt) begin
            mem_q.push_back('{addr: exp_pc, cyc: cyc, stale: 1'b0});
            exp_q.push_back({exp_pc, 32'h2000_0000 + exp_pc});
            if (first_grant_cyc < 0) first_grant_cyc = cyc;
            exp_pc = exp_pc + 32'd4;
        end
        if (redir_req) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            exp_pc = {redir_pc[31:2], 2'b00};
            flush_cnt++;
            redir_cyc = cyc;
            got_addr_q.delete();
            got_after_redir = 0;
        end
        if (!exp_valid) stall_cnt++;
        redir_req = 0;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        mem_q.delete();
        exp_q.delete();
        exp_pc = 32'h0;
        stall_cnt = 0;
        flush_cnt = 0;
        rand_lat = 0;
        rand_gnt = 0;
        gnt_off = 0;
        mem_hold = 0;
        mem_lat = 1;
        ready_mode = 1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_mode = 1;
        rand_gnt = 0;
        rand_lat = 0;
        mem_hold = 0;
        gnt_off = 1;
        while ((exp_q.size() > 0 || mem_q.size() > 0) && n < 200) begin
            step();
            n++;
        end
        gnt_off = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imem_gnt = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: got req %b addr %h valid %b expected 0 0 0",
                     bus.imem_req, bus.imem_addr, bus.inst_valid);
        end
        checks++;
        if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0 || bus.inst_pc4 !== 32'h4) begin
            errors++;
            $display("FAIL reset_data: got inst %h pc %h pc4 %h expected 0 0 4",
                     bus.inst, bus.inst_pc, bus.inst_pc4);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_stall_cycles !== 16'h0 || perf_flush_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_perf: got %h %h expected 0 0", perf_stall_cycles, perf_flush_count);
        end
`endif
    endtask

    task automatic test_first_fetch();
        do_reset();
        first_grant_cyc = -1;
        first_valid_cyc = -1;
        deliveries = 0;
        repeat (12) step();
        checks++;
        if (first_valid_cyc - first_grant_cyc !== 2) begin
            errors++;
            $display("FAIL first_latency: got %0d cycles expected 2", first_valid_cyc - first_grant_cyc);
        end
        checks++;
        if (deliveries !== 10) begin
            errors++;
            $display("FAIL throughput: got %0d deliveries expected 10", deliveries);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready_mode = 0;
        dut_grants = 0;
        repeat (10) step();
        checks++;
        if (dut_grants !== DEPTH) begin
            errors++;
            $display("FAIL stall_grants: got %0d expected %0d", dut_grants, DEPTH);
        end
        drain();
    endtask

    task automatic test_redirect();
        do_reset();
        mem_hold = 1;
        repeat (2) step();
        capture_after_redir = 1;
        redir_req = 1;
        redir_pc = 32'h0000_0103;
        first_grant_after_redir_cyc = -1;
        step();
        mem_hold = 0;
        #1;
        checks++;
        if (bus.imem_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL redirect_addr: got %h expected 00000100", bus.imem_addr);
        end
        repeat (10) step();
        checks++;
        if (first_grant_after_redir_cyc - redir_cyc !== 3 || got_addr_q.size() == 0 || got_addr_q[0] !== 32'h100) begin
            errors++;
            $display("FAIL redirect_refetch: got delay %0d first addr %h expected 3 00000100",
                     first_grant_after_redir_cyc - redir_cyc, (got_addr_q.size() > 0) ? got_addr_q[0] : 32'hX);
        end
        checks++;
        if (got_after_redir !== 1'b1 || first_pc_after_redir !== 32'h100) begin
            errors++;
            $display("FAIL redirect_first_pc: got %h expected 00000100", first_pc_after_redir);
        end
        capture_after_redir = 0;
    endtask

    task automatic test_pc_wrap();
        do_reset();
        repeat (3) step();
        capture_after_redir = 1;
        redir_req = 1;
        redir_pc = 32'hFFFF_FFF8;
        step();
        repeat (10) step();
        checks++;
        if (got_addr_q.size() < 3 || got_addr_q[0] !== 32'hFFFF_FFF8 ||
            got_addr_q[1] !== 32'hFFFF_FFFC || got_addr_q[2] !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: got %0d addrs, first %h expected FFFFFFF8 FFFFFFFC 00000000",
                     got_addr_q.size(), (got_addr_q.size() > 0) ? got_addr_q[0] : 32'hX);
        end
        capture_after_redir = 0;
        drain();
    endtask

    task automatic test_random();
        do_reset();
        rand_gnt = 1;
        rand_lat = 1;
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                redir_req = 1;
                redir_pc = $urandom();
            end
            step();
        end
        drain();
    endtask

    task automatic test_async_reset();
        logic [31:0] late_q[$];
        do_reset();
        mem_hold = 1;
        ready_mode = 0;
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got req %b valid %b addr %h expected 0 0 0",
                     bus.imem_req, bus.inst_valid, bus.imem_addr);
        end
        foreach (mem_q[i]) late_q.push_back(mem_q[i].addr);
        mem_q.delete();
        exp_q.delete();
        exp_pc = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        bus.imem_gnt = 1'b0;
        bus.redirect = 1'b0;
        bus.inst_ready = 1'b1;
        for (int i = 0; i <= late_q.size(); i++) begin
            bus.imem_rvalid = (i < late_q.size());
            bus.imem_rdata = (i < late_q.size()) ? 32'h2000_0000 + late_q[i] : 32'h0;
            #1;
            checks++;
            if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
                errors++;
                $display("FAIL late_rvalid %0d: got valid %b req %b addr %h expected 0 1 00000000",
                         i, bus.inst_valid, bus.imem_req, bus.imem_addr);
            end
            @(negedge clk);
        end
        mem_hold = 0;
        ready_mode = 1;
        repeat (10) step();
        drain();
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        test_redirect();
        checks++;
        if (perf_flush_count !== 16'd1) begin
            errors++;
            $display("FAIL perf_flush: got %0d expected 1", perf_flush_count);
        end
        checks++;
        if (perf_stall_cycles !== 16'(stall_cnt)) begin
            errors++;
            $display("FAIL perf_stall: got %0d expected %0d", perf_stall_cycles, stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect();
        test_pc_wrap();
        test_random();
        test_async_reset();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
